interval_timer_arbiter: RTL and testbench
=========================================

Name: interval_timer_arbiter

Overview:
- Shares a single interval counter among NUM_REQ requesters.
- Each requester asks for a one-shot delay of D clock cycles. The block grants the timer to one requester at a time using round-robin order, then times the delay and returns a one-cycle done pulse to the owner.
- Used by slow peripherals (UART bit timers, LED/PWM refresh, debounce) that would otherwise each need their own rollover counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- NUM_BITS, 16, width of each delay value and of the internal counter.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort of the current interval.
- req  input  NUM_REQ  per-requester request level.
- delay  input  NUM_REQ*NUM_BITS  packed delays; requester i uses bits [i*NUM_BITS +: NUM_BITS].
- grant  output  NUM_REQ  one-hot owner of the timer.
- done  output  NUM_REQ  one-hot, one-cycle completion pulse.
- busy  output  1  timer owned (state RUN or DONE).
- count  output  NUM_BITS  elapsed cycles of the current interval.

Behaviour:
- Reset (async, n_rst low):
  - state=IDLE; grant=0, done=0, busy=0, count=0.
  - Round-robin pointer ptr=0; latched delay=0.
- Reset mid-interval drops everything immediately. No done pulse is emitted.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If any req bit is set, select the first set index scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - On the next edge: grant[sel]=1, busy=1, count=0, latch D=delay[sel], ptr=(sel+1) mod NUM_REQ, go to RUN.
  - If no req bit is set, stay in IDLE; ptr is unchanged.
- Delay latching:
  - D=0 is treated as D=1.
  - Changes to delay after latching are ignored until the next grant.
- RUN:
  - count increments by 1 per cycle.
  - When count==D-1, go to DONE on the next edge.
- DONE:
  - done[sel]=1 for exactly one cycle; grant and busy are still high.
  - Next edge: grant=0, busy=0, done=0, count=0, go to IDLE.
- Latency:
  - req sampled in IDLE at cycle 0 → grant rises at cycle 1 → done pulse at cycle 1+D → grant falls at cycle 2+D.
  - Minimum spacing between consecutive grants is one IDLE cycle.
- Abort by requester: if req[sel] drops while in RUN, the next edge goes to IDLE with grant=0, busy=0, count=0. No done pulse.
- Abort by clear:
  - clear high in RUN or DONE → next edge goes to IDLE; all outputs 0; no done pulse.
  - If clear coincides with DONE, the done pulse already on the outputs this cycle stands, and no further pulse follows.
  - clear in IDLE blocks arbitration for that cycle.
  - ptr is not restored on abort; the aborted requester has already consumed its turn.
- Re-request: a requester still holding req in the DONE cycle is re-arbitrated in the following IDLE cycle like any other requester.
- Fairness: with all req bits held high, grants rotate 0,1,2,…,NUM_REQ-1,0,…
- Arithmetic:
  - The count comparison is NUM_BITS wide and unsigned.
  - D=2^NUM_BITS-1 gives the maximum interval, with no wrap of count.

Test Plan:
- Single request: req=0001, delay0=5 → grant=0001 at cycle 1; done=0001 at cycle 6 only; grant=0 at cycle 7; count goes 0..4 during RUN.
- Round robin: all req held, all delays=3 → grant order 0,1,2,3,0; each done is a single pulse; grants are 5 cycles apart.
- Zero delay: delay2=0, req=0100 → behaves as D=1; done=0100 at cycle 2.
- Requester abort: req0 delay=10, req0 dropped at cycle 4 → grant=0 at cycle 5; done never asserts; a pending req1 is granted at cycle 6.
- clear in RUN: delay1=8, clear pulsed at cycle 3 → outputs 0 at cycle 4; no done; next grant goes to index 2 if pending, not index 1.
- Reset mid-RUN: n_rst low at cycle 3 → grant, busy, count and done are 0 asynchronously. After release with req=1000 held, index 0 has priority again, so the first grant is index 3.

Source files
------------

// File: rtl/interval_timer_arbiter.sv
// interval_timer_arbiter
//   Shares one interval counter among NUM_REQ requesters. The timer is granted
//   round-robin. The owner's delay D is latched at grant time, with D=0 treated
//   as 1. After D cycles the owner gets a one-cycle done pulse, and the block
//   then returns to IDLE.
//
// Ports
//   clk    : system clock
//   n_rst  : asynchronous active-low reset
//   clear  : synchronous abort of the current interval; blocks arbitration in IDLE
//   req    : per-requester request level
//   delay  : packed delays, requester i at [i*NUM_BITS +: NUM_BITS]
//   grant  : one-hot timer owner
//   done   : one-hot, one-cycle completion pulse
//   busy   : timer owned (RUN or DONE)
//   count  : elapsed cycles of the current interval
//
// state | meaning
// IDLE  | no owner; arbitrate among req when clear is low
// RUN   | counting; leave at count==D-1, or abort on clear or req drop
// DONE  | done pulse is on the outputs; back to IDLE on the next edge

module interval_timer_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BITS = 16
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         clear,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*NUM_BITS-1:0]  delay,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy,
    output logic [NUM_BITS-1:0]          count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q,  done_d;
    logic                 busy_q,  busy_d;
    logic [NUM_BITS-1:0]  count_q, count_d;
    logic [NUM_BITS-1:0]  dly_q,   dly_d;
    logic [IDX_W-1:0]     ptr_q,   ptr_d;
    logic [IDX_W-1:0]     sel_q,   sel_d;

    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_BITS-1:0]  win_dly;

    // Round-robin scan starting at ptr_q.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
        win_dly = delay[int'(win_idx)*NUM_BITS +: NUM_BITS];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        count_d = count_q;
        dly_d   = dly_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;

        unique case (state_q)
            IDLE: begin
                if (!clear && found) begin
                    state_d          = RUN;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    busy_d           = 1'b1;
                    count_d          = '0;
                    sel_d            = win_idx;
                    dly_d            = (win_dly == '0) ? NUM_BITS'(1) : win_dly;
                    ptr_d            = (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + IDX_W'(1);
                end
            end
            RUN: begin
                if (clear || !req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                end else begin
                    // count reads D in the DONE cycle; D >= 1, so D-1 cannot wrap.
                    count_d = count_q + NUM_BITS'(1);
                    if (count_q == dly_q - NUM_BITS'(1)) begin
                        state_d        = DONE;
                        done_d[sel_q]  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            dly_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            dly_q   <= dly_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
module tb_interval_timer_arbiter;

    localparam int N = 4;
    localparam int B = 16;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           clear;
    logic [N-1:0]   req;
    logic [N*B-1:0] delay;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [B-1:0]   count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the timer, elapsed cycles, the latched delay,
    // whether this is the pulse cycle, and the round-robin start index.
    int  own;
    int  elapsed;
    int  dlen;
    bit  pulse;
    int  rr;

    interval_timer_arbiter #(.NUM_REQ(N), .NUM_BITS(B)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .req   (req),
        .delay (delay),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        own = -1; elapsed = 0; dlen = 0; pulse = 0; rr = 0;
    endtask

    task automatic model_step();
        if (own < 0) begin
            if (!clear && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (rr + k) % N;
                    if (own < 0 && req[i]) own = i;
                end
                elapsed = 0;
                pulse   = 0;
                dlen    = int'(delay[own*B +: B]);
                if (dlen == 0) dlen = 1;
                rr = (own + 1) % N;
            end
        end else if (pulse || clear || !req[own]) begin
            own = -1; elapsed = 0; pulse = 0;
        end else begin
            elapsed++;
            if (elapsed == dlen) pulse = 1;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg, ed;
        eg = '0; ed = '0;
        if (own >= 0) eg[own] = 1'b1;
        if (pulse) ed = eg;
        chk("grant", 32'(grant), 32'(eg));
        chk("done",  32'(done),  32'(ed));
        chk("busy",  32'(busy),  32'(own >= 0));
        chk("count", 32'(count), 32'(elapsed));
    endtask

    // Called at a negedge: drive inputs, let one edge pass, then compare.
    task automatic cyc(input logic [N-1:0] r, input logic c);
        req = r; clear = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_dly(input int i, input int v);
        delay[i*B +: B] = B'(v);
    endtask

    task automatic hard_reset();
        n_rst = 1'b0;
        #1;
        model_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done",  32'(done),  32'd0);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b1; clear = 1'b0; req = '0; delay = '0;
        model_reset();
        @(negedge clk);
        hard_reset();
        cyc('0, 1'b0);

        // Single request, D=5: grant in cycles 1..6, done only in cycle 6.
        set_dly(0, 5);
        for (int k = 1; k <= 8; k++) begin
            cyc((k <= 6) ? 4'b0001 : 4'b0000, 1'b0);
            chk("sp_grant", 32'(grant), ((k >= 1 && k <= 6) ? 32'd1 : 32'd0));
            chk("sp_done",  32'(done),  ((k == 6) ? 32'd1 : 32'd0));
            if (k <= 5) chk("sp_count", 32'(count), 32'(k - 1));
        end

        // Round robin with all requests held and D=3.
        for (int i = 0; i < N; i++) set_dly(i, 3);
        for (int k = 0; k < 26; k++) cyc(4'b1111, 1'b0);
        cyc('0, 1'b0); cyc('0, 1'b0); cyc('0, 1'b0);

        // Zero delay on requester 2 behaves as D=1.
        set_dly(2, 0);
        cyc(4'b0100, 1'b0);
        chk("zd_grant", 32'(grant), 32'h4);
        cyc(4'b0100, 1'b0);
        chk("zd_done", 32'(done), 32'h4);
        cyc('0, 1'b0); cyc('0, 1'b0);

        // clear in RUN: no done, and the pointer has already moved past the owner.
        hard_reset();
        set_dly(1, 8); set_dly(2, 2);
        cyc(4'b0010, 1'b0);
        chk("clr_grant", 32'(grant), 32'h2);
        cyc(4'b0010, 1'b0);
        cyc(4'b0110, 1'b1);
        chk("clr_idle", 32'(busy), 32'd0);
        cyc(4'b0110, 1'b0);
        chk("clr_next", 32'(grant), 32'h4);
        for (int k = 0; k < 6; k++) cyc('0, 1'b0);

        // Reset mid-RUN, then requester 3 alone gets the first grant.
        set_dly(0, 9);
        cyc(4'b0001, 1'b0); cyc(4'b0001, 1'b0);
        hard_reset();
        cyc(4'b1000, 1'b0);
        chk("rr_after_rst", 32'(grant), 32'h8);
        for (int k = 0; k < 8; k++) cyc('0, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] r;
            logic         c;
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < N; i++) set_dly(i, int'($urandom_range(0, 7)));
            r = (($urandom_range(0, 3) == 0) ? N'($urandom) : (req | N'($urandom_range(0, 1) << $urandom_range(0, N-1))));
            if ($urandom_range(0, 9) == 0) r = N'($urandom);
            c = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 599) == 0) hard_reset();
            cyc(r, c);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
